// File: rtl/seq_pkg.sv
// Shared types and width helpers for the serial pattern sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET_DUT,
      SHIFT,
      DRAIN,
      DONE
   } seq_state_t;

   // Width of the length port: must represent 0..W inclusive.
   function automatic int len_width(input int w);
      return $clog2(w) + 1;
   endfunction

   // Phase counter only needs to reach the longest phase minus one.
   function automatic int phase_width(input int w, input int r, input int d);
      int m;
      m = w;
      if (r > m) m = r;
      if (d > m) m = d;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

   function automatic int hit_width(input int w, input int d);
      return $clog2(w + d + 1);
   endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Pattern holding register: parallel load, shift right, LSB presented first.
module seq_shift_reg
   import seq_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         shift_en,
   output logic         lsb
);

   logic [W-1:0] data;

   always_ff @(posedge clock) begin
      if (reset) begin
         data <= '0;
      end else if (load) begin
         data <= load_value;
      end else if (shift_en) begin
         data <= {1'b0, data[W-1:1]};
      end
   end

   assign lsb = data[0];

endmodule

// File: rtl/serial_pattern_sequencer.sv
// Sequences a serial detector FSM: reset it, shift a pattern in, drain, count Out-high cycles.
// Optional SEQ_FIRST_HIT_EN adds first_hit/first_hit_vld reporting the first Out-high index.
module serial_pattern_sequencer
   import seq_pkg::*;
#(
   parameter  int W            = 16,
   parameter  int CNT_W        = 8,
   parameter  int RST_CYCLES   = 2,
   parameter  int DRAIN_CYCLES = 2,
   localparam int LEN_W        = len_width(W),
   localparam int HIT_W        = hit_width(W, DRAIN_CYCLES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [W-1:0]     pattern,
   input  logic [LEN_W-1:0] length,
   output logic             busy,
   output logic             done,
   output logic             fsm_reset_b,
   output logic             fsm_in,
   input  logic             fsm_out,
   output logic [CNT_W-1:0] det_count
`ifdef SEQ_FIRST_HIT_EN
   ,
   output logic [HIT_W-1:0] first_hit,
   output logic             first_hit_vld
`endif
);

   localparam int PH_W = phase_width(W, RST_CYCLES, DRAIN_CYCLES);

   seq_state_t       state;
   seq_state_t       next_state;
   seq_state_t       after_shift;
   logic [LEN_W-1:0] len_eff;
   logic [PH_W-1:0]  phase_cnt;
   logic             phase_last;
   logic             accept;
   logic             sampling;
   logic             sr_lsb;

   assign accept   = (state == IDLE) && start;
   assign sampling = (state == SHIFT) || (state == DRAIN);

   seq_shift_reg #(
      .W(W)
   ) u_shift (
      .clock     (clock),
      .reset     (reset),
      .load      (accept),
      .load_value(pattern),
      .shift_en  (next_state == SHIFT),
      .lsb       (sr_lsb)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Zero-length shift and zero-length drain phases are skipped entirely.
   always_comb begin
      next_state  = state;
      phase_last  = 1'b0;
      after_shift = (DRAIN_CYCLES != 0) ? DRAIN : DONE;
      case (state)
         IDLE: begin
            if (start) next_state = RESET_DUT;
         end
         RESET_DUT: begin
            phase_last = (int'(phase_cnt) == RST_CYCLES - 1);
            if (phase_last) next_state = (len_eff != '0) ? SHIFT : after_shift;
         end
         SHIFT: begin
            phase_last = (int'(phase_cnt) == int'(len_eff) - 1);
            if (phase_last) next_state = after_shift;
         end
         DRAIN: begin
            phase_last = (int'(phase_cnt) == DRAIN_CYCLES - 1);
            if (phase_last) next_state = DONE;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Outputs are registered from next_state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_cnt   <= '0;
         len_eff     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fsm_reset_b <= 1'b0;
         fsm_in      <= 1'b0;
         det_count   <= '0;
      end else begin
         phase_cnt   <= (next_state != state) ? '0 : phase_cnt + 1'b1;
         busy        <= (next_state == RESET_DUT) || (next_state == SHIFT) || (next_state == DRAIN);
         done        <= (next_state == DONE);
         fsm_reset_b <= (next_state != RESET_DUT);
         fsm_in      <= (next_state == SHIFT) && sr_lsb;
         if (accept) begin
            len_eff   <= (int'(length) > W) ? LEN_W'(W) : length;
            det_count <= '0;
         end else if (sampling && fsm_out && (det_count != '1)) begin
            det_count <= det_count + 1'b1;
         end
      end
   end

`ifdef SEQ_FIRST_HIT_EN
   logic [HIT_W-1:0] hit_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         hit_idx       <= '0;
         first_hit     <= '0;
         first_hit_vld <= 1'b0;
      end else if (accept) begin
         hit_idx       <= '0;
         first_hit     <= '0;
         first_hit_vld <= 1'b0;
      end else if (sampling) begin
         hit_idx <= hit_idx + 1'b1;
         if (fsm_out && !first_hit_vld) begin
            first_hit     <= hit_idx;
            first_hit_vld <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_pattern_sequencer.sv
// Randomized scoreboard bench for serial_pattern_sequencer with an in-bench "11" detector.
module tb_serial_pattern_sequencer;

   localparam int W        = 16;
   localparam int CNT_W    = 4;
   localparam int RST      = 2;
   localparam int DRAIN    = 2;
   localparam int LEN_W    = $clog2(W) + 1;
   localparam int HIT_W    = $clog2(W + DRAIN + 1);
   localparam int CNT_MAX  = (1 << CNT_W) - 1;
   localparam int M_ZERO   = 0;
   localparam int M_ONE    = 1;
   localparam int M_RAND   = 2;
   localparam int M_DET    = 3;

   typedef struct {
      int          c0;
      int          len;
      logic [15:0] pat;
      int          cnt;
      int          first;
      bit          vld;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [W-1:0]     pattern = '0;
   logic [LEN_W-1:0] length = '0;
   logic             busy;
   logic             done;
   logic             fsm_reset_b;
   logic             fsm_in;
   logic             fsm_out;
   logic [CNT_W-1:0] det_count;
`ifdef SEQ_FIRST_HIT_EN
   logic [HIT_W-1:0] first_hit;
   logic             first_hit_vld;
`endif

   exp_t sb[$];
   int   cyc = 0;
   int   cur_c0 = 0;
   int   mode = M_ZERO;
   bit   rbits[64];
   logic rst_q = 1'b0;
   logic det_prev = 1'b0;
   logic det_out = 1'b0;
   int   total = 0;
   int   passed = 0;
   int   last_cnt = 0;
   int   last_first = 0;
   bit   last_vld = 1'b0;

   serial_pattern_sequencer #(
      .W(W), .CNT_W(CNT_W), .RST_CYCLES(RST), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .pattern    (pattern),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .fsm_reset_b(fsm_reset_b),
      .fsm_in     (fsm_in),
      .fsm_out    (fsm_out),
      .det_count  (det_count)
`ifdef SEQ_FIRST_HIT_EN
      ,
      .first_hit    (first_hit),
      .first_hit_vld(first_hit_vld)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Stand-in detector: Out rises the cycle after two consecutive 1s were shifted in.
   always @(posedge clock) begin
      if (fsm_reset_b !== 1'b1) begin
         det_prev <= 1'b0;
         det_out  <= 1'b0;
      end else begin
         det_out  <= det_prev & fsm_in;
         det_prev <= fsm_in;
      end
   end

   always_comb begin
      fsm_out = 1'b0;
      case (mode)
         M_ONE:   fsm_out = 1'b1;
         M_RAND:  fsm_out = rbits[(cyc - cur_c0) & 63];
         M_DET:   fsm_out = det_out;
         default: fsm_out = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
   endtask

   // Reference: the detector sees bits pattern[0..len-1] then zeros, sampled over len+DRAIN cycles.
   function automatic exp_t model(input int c0, input logic [15:0] pat, input int len_req, input int md);
      exp_t e;
      int   v;
      int   le;
      le = (len_req > W) ? W : len_req;
      e.c0 = c0; e.len = le; e.pat = pat; e.cnt = 0; e.first = 0; e.vld = 1'b0;
      for (int j = 0; j < le + DRAIN; j++) begin
         case (md)
            M_ONE:   v = 1;
            M_RAND:  v = int'(rbits[(1 + RST + j) & 63]);
            M_DET:   v = (j >= 2 && (j - 1) < le && pat[j-1] && pat[j-2]) ? 1 : 0;
            default: v = 0;
         endcase
         if (v == 1) begin
            if (e.cnt < CNT_MAX) e.cnt++;
            if (!e.vld) begin
               e.vld   = 1'b1;
               e.first = j;
            end
         end
      end
      return e;
   endfunction

   // Monitor: every cycle, compare handshake/FSM-drive outputs with the expected run timeline.
   always @(negedge clock) begin
      int   off;
      int   done_off;
      logic [3:0] ew;
      if (rst_q) begin
         checkOutput("reset_outputs", {busy, done, fsm_reset_b, fsm_in, 28'(det_count)}, 32'h0);
         sb.delete();
         last_cnt = 0; last_first = 0; last_vld = 1'b0;
`ifdef SEQ_FIRST_HIT_EN
         checkOutput("reset_first_hit", {first_hit_vld, first_hit}, 32'h0);
`endif
      end else if (sb.size() > 0 && cyc > sb[0].c0) begin
         off      = cyc - sb[0].c0;
         done_off = 1 + RST + sb[0].len + DRAIN;
         if (off <= RST) ew = 4'b1000;
         else if (off <= RST + sb[0].len) ew = {3'b101, sb[0].pat[off-RST-1]};
         else if (off < done_off) ew = 4'b1010;
         else ew = 4'b0110;
         checkOutput("busy_done_rstb_in", {busy, done, fsm_reset_b, fsm_in}, ew);
         if (off >= done_off) begin
            checkOutput("det_count", det_count, sb[0].cnt);
`ifdef SEQ_FIRST_HIT_EN
            checkOutput("first_hit", {first_hit_vld, first_hit}, {sb[0].vld, HIT_W'(sb[0].first)});
`endif
            last_cnt = sb[0].cnt; last_first = sb[0].first; last_vld = sb[0].vld;
            void'(sb.pop_front());
         end
      end else begin
         checkOutput("idle_outputs", {busy, done, fsm_reset_b, fsm_in}, 4'b0010);
         checkOutput("det_count_held", det_count, last_cnt);
`ifdef SEQ_FIRST_HIT_EN
         checkOutput("first_hit_held", {first_hit_vld, first_hit}, {last_vld, HIT_W'(last_first)});
`endif
      end
   end

   task automatic applyStimulus(input logic [15:0] pat, input int len_req, input int md);
      @(posedge clock); #1;
      mode = md;
      if (md == M_RAND) begin
         for (int i = 0; i < 64; i++) rbits[i] = 1'($urandom);
      end
      cur_c0  = cyc;
      pattern = pat;
      length  = LEN_W'(len_req);
      start   = 1'b1;
      sb.push_back(model(cyc, pat, len_req, md));
      @(posedge clock); #1;
      start   = 1'b0;
      pattern = 16'($urandom);
      length  = LEN_W'($urandom);
   endtask

   task automatic waitRun();
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clock);
      checkOutput("run_timeout", sb.size(), 0);
      sb.delete();
   endtask

   task automatic waitCycle(input int target);
      for (int i = 0; i < 100 && cyc < target; i++) begin
         @(posedge clock); #1;
      end
   endtask

   // Pulses start at a given offset of the current run without expecting it to be accepted.
   task automatic pulseIgnored(input int off);
      waitCycle(sb[0].c0 + off);
      start   = 1'b1;
      pattern = 16'hFFFF;
      length  = LEN_W'(16);
      @(posedge clock); #1;
      start   = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);

      applyStimulus(16'h00A5, 8, M_ZERO);
      waitRun();
      applyStimulus(16'h1234, 5, M_ONE);
      waitRun();
      applyStimulus(16'h1234, 0, M_ONE);
      waitRun();
      applyStimulus(16'hBEEF, 16, M_ONE);
      waitRun();
      applyStimulus(16'h5A5A, 20, M_ONE);
      waitRun();

      applyStimulus(16'h0F0F, 6, M_ONE);
      pulseIgnored(3);
      pulseIgnored(1 + RST + 6 + DRAIN);
      waitRun();

      applyStimulus(16'hFFFF, 10, M_ONE);
      waitCycle(cur_c0 + RST + 4);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      applyStimulus(16'h00A5, 8, M_ONE);
      waitRun();

      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      applyStimulus(16'h0006, 4, M_DET);
      waitRun();
      applyStimulus(16'hFFFF, 16, M_DET);
      waitRun();

      for (int n = 0; n < 40; n++) begin
         applyStimulus(16'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
         waitRun();
      end

      repeat (3) @(posedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
